// File: rtl/fpu_mul_pkg.sv
// Shared types and FP32 constants for the multiplier controller.
package fpu_mul_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_PACK,
        ST_RESP
    } state_e;

    localparam int FP_W       = 32;
    localparam int MANT_W     = 24;
    localparam int NORM_W     = 25;
    localparam int SHL_W      = 5;
    localparam int FP_BIAS    = 127;
    localparam int FP_EXP_MAX = 255;

    localparam logic [FP_W-1:0] FP_QNAN = 32'h7FC0_0000;

    // The datapath always sees a normal mantissa; exponent 0 is not special here.
    function automatic logic [MANT_W-1:0] mantOf(input logic [FP_W-1:0] x);
        return {1'b1, x[22:0]};
    endfunction

endpackage

// File: rtl/fmul_ctrl_rr_arb2.sv
// Two-way round-robin arbiter; the pointer moves past the winner only when update_i is set.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] valid_i,
    input  logic       update_i,
    output logic [1:0] grant_o,
    output logic       grant_id_o
);

    logic ptr_q;

    always_comb begin
        grant_o = valid_i;
        if (valid_i == 2'b11) begin
            grant_o = ptr_q ? 2'b10 : 2'b01;
        end
        grant_id_o = grant_o[1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= 1'b0;
        end else if (update_i) begin
            ptr_q <= ~grant_id_o;
        end
    end

endmodule

// File: rtl/fmul_ctrl.sv
// Shares one FP32 mantissa multiply/normalize datapath between two requesters.
// Define FMUL_SPECIAL_EN to resolve zero/inf/NaN operands without using the datapath.
module fmul_ctrl
    import fpu_mul_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  req_valid,
    output logic [1:0]  req_ready,
    input  logic [63:0] req_a,
    input  logic [63:0] req_b,
    output logic        dp_start,
    output logic [23:0] dp_mant_a,
    output logic [23:0] dp_mant_b,
    input  logic        dp_done,
    input  logic [24:0] dp_norm,
    input  logic [4:0]  dp_shl,
    input  logic        dp_ovf,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [31:0] rsp_result,
    output logic [1:0]  rsp_flags
);

    localparam logic signed [9:0] BIAS_S    = 10'(FP_BIAS);
    localparam logic signed [9:0] EXP_MAX_S = 10'(FP_EXP_MAX);

    state_e            state_q;
    logic [1:0]        grant;
    logic              grantId;
    logic              isIdle;
    logic              accept;
    logic [FP_W-1:0]   selA;
    logic [FP_W-1:0]   selB;

    logic              signA_q;
    logic              signB_q;
    logic [7:0]        expA_q;
    logic [7:0]        expB_q;
    logic              id_q;
    logic [22:0]       normFrac_q;
    logic [SHL_W-1:0]  shl_q;
    logic              ovf_q;

    logic              dpStart_q;
    logic [MANT_W-1:0] mantA_q;
    logic [MANT_W-1:0] mantB_q;
    logic              rspValid_q;
    logic              rspId_q;
    logic [FP_W-1:0]   rspResult_q;
    logic [1:0]        rspFlags_q;

    logic signed [9:0] expSum;
    logic              packSign;
    logic [FP_W-1:0]   packResult;
    logic [1:0]        packFlags;
    logic              unusedNormBits;

    assign isIdle    = (state_q == ST_IDLE);
    assign req_ready = grant & {2{isIdle}};
    assign accept    = |(req_valid & req_ready);
    assign selA      = grantId ? req_a[63:32] : req_a[31:0];
    assign selB      = grantId ? req_b[63:32] : req_b[31:0];

    // Hidden bit and sticky come back from the datapath but truncation never needs them.
    assign unusedNormBits = dp_norm[24] ^ dp_norm[0];

    rr_arb2 u_arb (
        .clk        (clk),
        .rst_n      (rst_n),
        .valid_i    (req_valid),
        .update_i   (accept),
        .grant_o    (grant),
        .grant_id_o (grantId)
    );

`ifdef FMUL_SPECIAL_EN
    logic            aZero, bZero, aInf, bInf, aNan, bNan, specSign;
    logic            isSpecial;
    logic [FP_W-1:0] specResult;

    assign aZero    = (selA[30:23] == 8'h00);
    assign bZero    = (selB[30:23] == 8'h00);
    assign aInf     = (selA[30:23] == 8'hFF) && (selA[22:0] == 23'd0);
    assign bInf     = (selB[30:23] == 8'hFF) && (selB[22:0] == 23'd0);
    assign aNan     = (selA[30:23] == 8'hFF) && (selA[22:0] != 23'd0);
    assign bNan     = (selB[30:23] == 8'hFF) && (selB[22:0] != 23'd0);
    assign specSign = selA[31] ^ selB[31];

    // NaN wins over inf, inf over zero; 0 x inf is invalid and also yields the quiet NaN.
    always_comb begin
        isSpecial  = 1'b1;
        specResult = {specSign, 31'd0};
        if (aNan || bNan || (aZero && bInf) || (aInf && bZero)) begin
            specResult = FP_QNAN;
        end else if (aInf || bInf) begin
            specResult = {specSign, 8'hFF, 23'd0};
        end else if (aZero || bZero) begin
            specResult = {specSign, 31'd0};
        end else begin
            isSpecial = 1'b0;
        end
    end
`endif

    // Ten signed bits cover every sum from 0+0-127-31 up to 255+255-127+1.
    always_comb begin
        packSign   = signA_q ^ signB_q;
        expSum     = $signed({2'b00, expA_q}) + $signed({2'b00, expB_q}) - BIAS_S
                   + $signed({9'd0, ovf_q}) - $signed({5'd0, shl_q});
        packResult = {packSign, expSum[7:0], normFrac_q};
        packFlags  = 2'b00;
        if (expSum >= EXP_MAX_S) begin
            packResult = {packSign, 8'hFF, 23'd0};
            packFlags  = 2'b10;
        end else if (expSum <= 10'sd0) begin
            packResult = {packSign, 31'd0};
            packFlags  = 2'b01;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            signA_q     <= 1'b0;
            signB_q     <= 1'b0;
            expA_q      <= 8'd0;
            expB_q      <= 8'd0;
            id_q        <= 1'b0;
            normFrac_q  <= 23'd0;
            shl_q       <= '0;
            ovf_q       <= 1'b0;
            dpStart_q   <= 1'b0;
            mantA_q     <= '0;
            mantB_q     <= '0;
            rspValid_q  <= 1'b0;
            rspId_q     <= 1'b0;
            rspResult_q <= '0;
            rspFlags_q  <= 2'b00;
        end else begin
            dpStart_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        signA_q <= selA[31];
                        signB_q <= selB[31];
                        expA_q  <= selA[30:23];
                        expB_q  <= selB[30:23];
                        id_q    <= grantId;
                        mantA_q <= mantOf(selA);
                        mantB_q <= mantOf(selB);
`ifdef FMUL_SPECIAL_EN
                        if (isSpecial) begin
                            rspResult_q <= specResult;
                            rspFlags_q  <= 2'b00;
                            rspId_q     <= grantId;
                            rspValid_q  <= 1'b1;
                            state_q     <= ST_RESP;
                        end else begin
                            dpStart_q <= 1'b1;
                            state_q   <= ST_ISSUE;
                        end
`else
                        dpStart_q <= 1'b1;
                        state_q   <= ST_ISSUE;
`endif
                    end
                end
                ST_ISSUE: begin
                    state_q <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (dp_done) begin
                        normFrac_q <= dp_norm[23:1];
                        shl_q      <= dp_shl;
                        ovf_q      <= dp_ovf;
                        state_q    <= ST_PACK;
                    end
                end
                ST_PACK: begin
                    rspResult_q <= packResult;
                    rspFlags_q  <= packFlags;
                    rspId_q     <= id_q;
                    rspValid_q  <= 1'b1;
                    state_q     <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rspValid_q <= 1'b0;
                        state_q    <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign dp_start   = dpStart_q;
    assign dp_mant_a  = mantA_q;
    assign dp_mant_b  = mantB_q;
    assign rsp_valid  = rspValid_q;
    assign rsp_id     = rspId_q;
    assign rsp_result = rspResult_q;
    assign rsp_flags  = rspFlags_q;

endmodule

// File: tb/tb_fmul_ctrl.sv
// Bench for fmul_ctrl: directed and random multiplies checked against a field-level FP32 model,
// with a reactive datapath model answering dp_start.
module tb_fmul_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [63:0] req_a;
    logic [63:0] req_b;
    logic        dp_start;
    logic [23:0] dp_mant_a;
    logic [23:0] dp_mant_b;
    logic        dp_done;
    logic [24:0] dp_norm;
    logic [4:0]  dp_shl;
    logic        dp_ovf;
    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_id;
    logic [31:0] rsp_result;
    logic [1:0]  rsp_flags;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    fmul_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .dp_start   (dp_start),
        .dp_mant_a  (dp_mant_a),
        .dp_mant_b  (dp_mant_b),
        .dp_done    (dp_done),
        .dp_norm    (dp_norm),
        .dp_shl     (dp_shl),
        .dp_ovf     (dp_ovf),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_result (rsp_result),
        .rsp_flags  (rsp_flags)
    );

    // Observations of the most recent runOp transaction.
    logic        oAcc, oGid, oId, oFin, oPostValid;
    logic [31:0] oRes;
    logic [1:0]  oFlags, oRdyAfter;
    int          oLat, oStart, oRdyViol, oStabViol, oMantErr, oValidCycles;

    // Real-valued view of FP32 multiply: {flags, result} with truncation and flush-to-zero.
    function automatic logic [33:0] refMul(input logic [31:0] a, input logic [31:0] b);
        logic [47:0] prod;
        logic        sign;
        logic        ovf;
        logic [22:0] frac;
        int          e;
        sign = a[31] ^ b[31];
        prod = {1'b1, a[22:0]} * {1'b1, b[22:0]};
        ovf  = prod[47];
        frac = ovf ? prod[46:24] : prod[45:23];
        e    = int'(a[30:23]) + int'(b[30:23]) - 127 + int'(ovf);
        if (e >= 255) return {2'b10, sign, 8'hFF, 23'd0};
        if (e <= 0)   return {2'b01, sign, 31'd0};
        return {2'b00, sign, 8'(e), frac};
    endfunction

    task automatic doReset();
        rst_n     = 1'b0;
        req_valid = 2'b00;
        dp_done   = 1'b0;
        rsp_ready = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    // Presents one request, plays the datapath, and collects the response; no checking here.
    task automatic runOp(input logic [1:0] valid, input logic [63:0] a, input logic [63:0] b,
                         input int extraDelay, input int respDelay, input logic useOvr,
                         input logic [24:0] ovrNorm, input logic [4:0] ovrShl, input logic ovrOvf);
        logic [31:0] ga, gb;
        logic [47:0] prod;
        logic        readyPrev;
        int          doneAt;
        oAcc = 0; oGid = 0; oId = 0; oFin = 0; oPostValid = 0; oRes = 0; oFlags = 0;
        oRdyAfter = 0; oLat = -1; oStart = 0; oRdyViol = 0; oStabViol = 0; oMantErr = 0;
        oValidCycles = 0; doneAt = -1; readyPrev = 0;
        req_a = a; req_b = b; req_valid = valid;
        for (int w = 0; w < 20 && !oAcc; w++) begin
            #1;
            if (req_ready == 2'b11) oRdyViol++;
            if ((req_ready & req_valid) != 2'b00) begin
                oAcc = 1;
                oGid = req_ready[1];
            end
            @(posedge clk); #1;
        end
        if (oAcc) begin
            ga   = oGid ? a[63:32] : a[31:0];
            gb   = oGid ? b[63:32] : b[31:0];
            prod = {1'b1, ga[22:0]} * {1'b1, gb[22:0]};
            for (int k = 1; k <= 60 && !oFin; k++) begin
                dp_done = 1'b0;
                if (readyPrev) begin
                    oFin       = 1;
                    oRdyAfter  = req_ready;
                    oPostValid = rsp_valid;
                    rsp_ready  = 1'b0;
                end else begin
                    if (req_ready != 2'b00) oRdyViol++;
                    if (dp_start) begin
                        oStart++;
                        if (doneAt < 0) doneAt = k + 1 + extraDelay;
                    end
                    if (oStart > 0 && k <= doneAt &&
                        (dp_mant_a !== {1'b1, ga[22:0]} || dp_mant_b !== {1'b1, gb[22:0]})) oMantErr++;
                    if (k == doneAt) begin
                        dp_done = 1'b1;
                        dp_norm = useOvr ? ovrNorm : (prod[47] ? prod[47:23] : prod[46:22]);
                        dp_shl  = useOvr ? ovrShl : 5'd0;
                        dp_ovf  = useOvr ? ovrOvf : prod[47];
                    end
                    if (rsp_valid) begin
                        if (oValidCycles == 0) begin
                            oLat = k; oRes = rsp_result; oId = rsp_id; oFlags = rsp_flags;
                        end else if ({rsp_result, rsp_id, rsp_flags} !== {oRes, oId, oFlags}) begin
                            oStabViol++;
                        end
                        oValidCycles++;
                        rsp_ready = (oValidCycles > respDelay);
                        readyPrev = rsp_ready;
                    end
                end
                if (!oFin) begin
                    @(posedge clk); #1;
                end
            end
        end
        req_valid = 2'b00;
        rsp_ready = 1'b0;
        dp_done   = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_valid = 2'b00; req_a = '0; req_b = '0; rsp_ready = 1'b0;
        dp_done = 1'b0; dp_norm = '0; dp_shl = '0; dp_ovf = 1'b0;
        @(posedge clk); #1;
        total++;
        if ({req_ready, dp_start, rsp_valid, rsp_id, rsp_flags} !== 7'd0) begin
            bad++; $display("[TB] FAIL reset_ctrl got=%b exp=0", {req_ready, dp_start, rsp_valid, rsp_id, rsp_flags});
        end
        total++;
        if ({dp_mant_a, dp_mant_b} !== 48'd0) begin
            bad++; $display("[TB] FAIL reset_mant got=%h exp=0", {dp_mant_a, dp_mant_b});
        end
        total++;
        if (rsp_result !== 32'd0) begin
            bad++; $display("[TB] FAIL reset_result got=%h exp=0", rsp_result);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        total++;
        if ({req_ready, dp_start, rsp_valid} !== 4'd0) begin
            bad++; $display("[TB] FAIL post_reset_idle got=%b exp=0", {req_ready, dp_start, rsp_valid});
        end
    endtask

    task automatic test_basic();
        runOp(2'b01, {32'hDEAD_BEEF, 32'h3FC0_0000}, {32'h1234_5678, 32'h4000_0000}, 0, 0, 0, '0, '0, 0);
        total++;
        if (!(oAcc && oFin) || oGid !== 1'b0) begin
            bad++; $display("[TB] FAIL basic_handshake got=acc%0d fin%0d gid%0d exp=1 1 0", oAcc, oFin, oGid);
        end
        total++;
        if ({oFlags, oId, oRes} !== {2'b00, 1'b0, 32'h4040_0000}) begin
            bad++; $display("[TB] FAIL basic_result got=%b/%0d/%h exp=00/0/40400000", oFlags, oId, oRes);
        end
        total++;
        if (oLat !== 4 || oStart !== 1 || oMantErr !== 0 || oPostValid !== 1'b0) begin
            bad++; $display("[TB] FAIL basic_timing got=lat%0d start%0d mant%0d post%0d exp=4 1 0 0",
                            oLat, oStart, oMantErr, oPostValid);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 12; i++) begin
            logic [31:0] xa, xb, junk;
            logic        which;
            logic [33:0] expv;
            int          ed, rd;
            xa    = {1'($urandom), 8'($urandom_range(190, 64)), 23'($urandom)};
            xb    = {1'($urandom), 8'($urandom_range(190, 64)), 23'($urandom)};
            junk  = $urandom;
            which = 1'($urandom);
            ed    = $urandom_range(3, 0);
            rd    = $urandom_range(2, 0);
            expv  = refMul(xa, xb);
            runOp(which ? 2'b10 : 2'b01, which ? {xa, junk} : {junk, xa}, which ? {xb, ~junk} : {~junk, xb},
                  ed, rd, 0, '0, '0, 0);
            total++;
            if (!(oAcc && oFin) || oGid !== which || oId !== which) begin
                bad++; $display("[TB] FAIL rand_id[%0d] got=acc%0d fin%0d gid%0d id%0d exp=%0d", i, oAcc, oFin, oGid, oId, which);
            end
            total++;
            if ({oFlags, oRes} !== expv) begin
                bad++; $display("[TB] FAIL rand_result[%0d] a=%h b=%h got=%b/%h exp=%b/%h", i, xa, xb, oFlags, oRes, expv[33:32], expv[31:0]);
            end
            total++;
            if (oLat !== 4 + ed || oMantErr !== 0 || oStabViol !== 0 || oRdyViol !== 0) begin
                bad++; $display("[TB] FAIL rand_timing[%0d] got=lat%0d mant%0d stab%0d rdy%0d exp=lat%0d 0 0 0",
                                i, oLat, oMantErr, oStabViol, oRdyViol, 4 + ed);
            end
        end
    endtask

    task automatic test_arbitration();
        doReset();
        for (int i = 0; i < 4; i++) begin
            logic [31:0] a0, a1, b0, b1;
            logic [33:0] expv;
            a0 = {1'b0, 8'($urandom_range(150, 100)), 23'($urandom)};
            a1 = {1'b1, 8'($urandom_range(150, 100)), 23'($urandom)};
            b0 = {1'b0, 8'($urandom_range(150, 100)), 23'($urandom)};
            b1 = {1'b0, 8'($urandom_range(150, 100)), 23'($urandom)};
            expv = (i % 2 == 1) ? refMul(a1, b1) : refMul(a0, b0);
            runOp(2'b11, {a1, a0}, {b1, b0}, i, 0, 0, '0, '0, 0);
            total++;
            if (!(oAcc && oFin) || oGid !== 1'(i % 2) || oId !== 1'(i % 2)) begin
                bad++; $display("[TB] FAIL arb_order[%0d] got=gid%0d id%0d exp=%0d", i, oGid, oId, i % 2);
            end
            total++;
            if ({oFlags, oRes} !== expv || oRdyViol !== 0) begin
                bad++; $display("[TB] FAIL arb_result[%0d] got=%h rdy%0d exp=%h rdy0", i, oRes, oRdyViol, expv[31:0]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [33:0] expv;
        expv = refMul(32'h4120_0000, 32'hC0A0_0000);
        runOp(2'b11, {32'h4120_0000, 32'h4120_0000}, {32'hC0A0_0000, 32'hC0A0_0000}, 1, 5, 0, '0, '0, 0);
        total++;
        if (oValidCycles !== 6 || oStabViol !== 0 || oRdyViol !== 0) begin
            bad++; $display("[TB] FAIL backpressure_hold got=cyc%0d stab%0d rdy%0d exp=6 0 0", oValidCycles, oStabViol, oRdyViol);
        end
        total++;
        if ({oFlags, oRes} !== expv || oPostValid !== 1'b0) begin
            bad++; $display("[TB] FAIL backpressure_result got=%h post%0d exp=%h post0", oRes, oPostValid, expv[31:0]);
        end
        total++;
        if (oRdyAfter !== (oGid ? 2'b01 : 2'b10)) begin
            bad++; $display("[TB] FAIL next_grant got=%b exp=%b", oRdyAfter, oGid ? 2'b01 : 2'b10);
        end
    endtask

    task automatic test_ovf_uflow();
        runOp(2'b10, {32'h7F00_0000, 32'h0}, {32'h7F00_0000, 32'h0}, 0, 0, 0, '0, '0, 0);
        total++;
        if ({oFlags, oRes} !== {2'b10, 32'h7F80_0000} || oId !== 1'b1) begin
            bad++; $display("[TB] FAIL overflow got=%b/%h id%0d exp=10/7f800000 id1", oFlags, oRes, oId);
        end
        runOp(2'b01, {32'h0, 32'h8080_0000}, {32'h0, 32'h0080_0000}, 0, 0, 0, '0, '0, 0);
        total++;
        if ({oFlags, oRes} !== {2'b01, 32'h8000_0000}) begin
            bad++; $display("[TB] FAIL underflow got=%b/%h exp=01/80000000", oFlags, oRes);
        end
        // 2.0 x 1.0 with a datapath claiming a 3-bit left shift: exponent 128-3 and its fraction.
        runOp(2'b01, {32'h0, 32'h4000_0000}, {32'h0, 32'h3F80_0000}, 2, 0, 1, {1'b1, 23'h12_3456, 1'b1}, 5'd3, 1'b0);
        total++;
        if ({oFlags, oRes} !== {2'b00, 32'h3E92_3456}) begin
            bad++; $display("[TB] FAIL shift_adjust got=%b/%h exp=00/3e923456", oFlags, oRes);
        end
    endtask

    task automatic test_special();
`ifdef FMUL_SPECIAL_EN
        runOp(2'b01, {32'h0, 32'h0000_0000}, {32'h0, 32'h7F80_0000}, 0, 0, 0, '0, '0, 0);
        total++;
        if (oRes !== 32'h7FC0_0000 || oFlags !== 2'b00 || oLat !== 1 || oStart !== 0) begin
            bad++; $display("[TB] FAIL special_nan got=%h f%b lat%0d start%0d exp=7fc00000 f00 lat1 start0", oRes, oFlags, oLat, oStart);
        end
        runOp(2'b10, {32'h7F80_0000, 32'h0}, {32'hBF80_0000, 32'h0}, 0, 0, 0, '0, '0, 0);
        total++;
        if (oRes !== 32'hFF80_0000 || oLat !== 1 || oStart !== 0) begin
            bad++; $display("[TB] FAIL special_inf got=%h lat%0d exp=ff800000 lat1", oRes, oLat);
        end
        runOp(2'b01, {32'h0, 32'h8000_0001}, {32'h0, 32'h3F80_0000}, 0, 0, 0, '0, '0, 0);
        total++;
        if (oRes !== 32'h8000_0000 || oLat !== 1 || oStart !== 0) begin
            bad++; $display("[TB] FAIL special_zero got=%h lat%0d exp=80000000 lat1", oRes, oLat);
        end
`else
        logic [33:0] expv;
        expv = refMul(32'h0000_0000, 32'h7F80_0000);
        runOp(2'b01, {32'h0, 32'h0000_0000}, {32'h0, 32'h7F80_0000}, 0, 0, 0, '0, '0, 0);
        total++;
        if (oStart !== 1 || oLat !== 4) begin
            bad++; $display("[TB] FAIL nospecial_path got=start%0d lat%0d exp=start1 lat4", oStart, oLat);
        end
        total++;
        if ({oFlags, oRes} !== expv) begin
            bad++; $display("[TB] FAIL nospecial_result got=%b/%h exp=%b/%h", oFlags, oRes, expv[33:32], expv[31:0]);
        end
`endif
    endtask

    task automatic test_reset_in_wait();
        int seenValid, seenStart, seenReady;
        doReset();
        req_a = {32'h0, 32'h3FC0_0000};
        req_b = {32'h0, 32'h4000_0000};
        req_valid = 2'b01;
        #1;
        total++;
        if (req_ready !== 2'b01) begin
            bad++; $display("[TB] FAIL rw_grant got=%b exp=01", req_ready);
        end
        @(posedge clk); #1;
        req_valid = 2'b00;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        total++;
        if ({req_ready, dp_start, rsp_valid, rsp_id, rsp_flags, rsp_result, dp_mant_a, dp_mant_b} !== '0) begin
            bad++; $display("[TB] FAIL rw_async_reset got=%b/%h/%h exp=0", {req_ready, dp_start, rsp_valid}, dp_mant_a, rsp_result);
        end
        @(posedge clk); #1;
        rst_n   = 1'b1;
        dp_done = 1'b1; dp_norm = 25'h1FF_FFFF; dp_shl = 5'd0; dp_ovf = 1'b0;
        @(posedge clk); #1;
        dp_done = 1'b0;
        seenValid = 0; seenStart = 0; seenReady = 0;
        for (int k = 0; k < 8; k++) begin
            if (rsp_valid) seenValid++;
            if (dp_start) seenStart++;
            if (req_ready != 2'b00) seenReady++;
            @(posedge clk); #1;
        end
        total++;
        if (seenValid !== 0 || seenStart !== 0 || seenReady !== 0) begin
            bad++; $display("[TB] FAIL rw_stale_done got=valid%0d start%0d ready%0d exp=0 0 0", seenValid, seenStart, seenReady);
        end
        runOp(2'b11, {32'h3F80_0000, 32'h4000_0000}, {32'h4000_0000, 32'h3F80_0000}, 0, 0, 0, '0, '0, 0);
        total++;
        if (!(oAcc && oFin) || oGid !== 1'b0 || oRes !== 32'h4000_0000) begin
            bad++; $display("[TB] FAIL rw_ptr_reset got=gid%0d res=%h exp=gid0 res=40000000", oGid, oRes);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_random();
        test_arbitration();
        test_back_to_back();
        test_ovf_uflow();
        test_special();
        test_reset_in_wait();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog got=running exp=finished");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
